// File: rtl/mux_pkg.sv
// Shared types and constants for the N-channel streaming mux.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mux_nch_rr_rr_pick.sv
// Wrapped priority search: first requester after ptr, ptr itself checked last.
module rr_pick #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    int w_c;

    // Walk offsets 1..NCH from ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_c   = 0;
        for (int i = 1; i <= NCH; i++) begin
            w_c = (int'(ptr) + i) % NCH;
            if (!found && req[w_c]) begin
                found = 1'b1;
                idx   = SELW'(w_c);
            end
        end
    end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel registered mux with fixed-select or round-robin arbitration,
// valid/ready on every port and a wrapping accepted-beat counter.
module mux_nch_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_i,
    input  logic [SELW-1:0]      sel_i,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    input  logic [NCH-1:0]       in_valid_i,
    output logic [NCH-1:0]       in_ready_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SELW-1:0]      out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_W-1:0]     xfer_cnt_o
);

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic             r_valid;
    logic [SELW-1:0]  r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_rr_found;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_fix_found;
    logic             w_found;
    logic [SELW-1:0]  w_cand;
    logic [WIDTH-1:0] w_cand_data;

    assign w_load = !r_valid || out_ready_i;

    rr_pick #(.NCH(NCH)) u_pick (
        .req   (in_valid_i),
        .ptr   (r_ptr),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    // Fixed mode: compare sel against each real channel so an out-of-range
    // select simply matches nothing instead of indexing past the vector.
    always_comb begin
        w_fix_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_i == SELW'(k) && in_valid_i[k])
                w_fix_found = 1'b1;
        end
    end

    // Choose the candidate for the active mode.
    always_comb begin
        if (mux_mode_e'(mode_i) == MODE_RR) begin
            w_found = w_rr_found;
            w_cand  = w_rr_idx;
        end else begin
            w_found = w_fix_found;
            w_cand  = sel_i;
        end
    end

    // Data mux; only consumed when w_found, so w_cand is always in range there.
    always_comb begin
        w_cand_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_cand == SELW'(k))
                w_cand_data = in_data_i[k*WIDTH +: WIDTH];
        end
    end

    // One-hot ready to the granted channel; never during reset or stall.
    always_comb begin
        in_ready_o = '0;
        if (!rst && w_load && w_found) begin
            for (int k = 0; k < NCH; k++) begin
                if (w_cand == SELW'(k))
                    in_ready_o[k] = 1'b1;
            end
        end
    end

    // Output register, RR pointer and beat counter; all hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_ptr   <= SELW'(NCH - 1);
            r_cnt   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_data  <= w_cand_data;
                r_ch    <= w_cand;
                r_valid <= 1'b1;
                r_ptr   <= w_cand;
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data_o  = r_data;
    assign out_ch_o    = r_ch;
    assign out_valid_o = r_valid;
    assign xfer_cnt_o  = r_cnt;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Directed bench for mux_nch_rr: a 4-channel instance for the main scenarios
// and a 3-channel instance for the out-of-range select case.
module tb_mux_nch_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel DUT
    logic        rst, mode, out_ready;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic [15:0] cnt;

    mux_nch_rr #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst(rst), .mode_i(mode), .sel_i(sel),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_ch_o(out_ch), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .xfer_cnt_o(cnt)
    );

    // 3-channel DUT
    logic        rst3, mode3, out_ready3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic [15:0] cnt3;

    mux_nch_rr #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst(rst3), .mode_i(mode3), .sel_i(sel3),
        .in_data_i(in_data3), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .out_data_o(out_data3), .out_ch_o(out_ch3), .out_valid_o(out_valid3),
        .out_ready_i(out_ready3), .xfer_cnt_o(cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'b1111; in_data = 32'h44332211;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h ch=%0d cnt=%0d, want 0/00/0/0",
                     out_valid, out_data, out_ch, cnt);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b want 0000", in_ready);
        end
    endtask

    task automatic test_fixed();
        rst = 1'b0; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        in_valid = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready: in_ready=%b want 0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL fixed_out: valid=%b data=%h ch=%0d cnt=%0d, want 1/a5/2/1",
                     out_valid, out_data, out_ch, cnt);
        end
        // No candidate: output drains, data and channel hold.
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_idle_ready: in_ready=%b want 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL fixed_empty: valid=%b data=%h ch=%0d cnt=%0d, want 0/a5/2/1",
                     out_valid, out_data, out_ch, cnt);
        end
    endtask

    task automatic test_rr_all();
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] ech;
            ech = 2'(i % 4);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== ech || out_data !== (8'h10 + 8'(ech))
                || cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL rr_all[%0d]: valid=%b ch=%0d data=%h cnt=%0d, want 1/%0d/%h/%0d",
                         i, out_valid, out_ch, out_data, cnt, ech, 8'h10 + 8'(ech), i + 1);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] seq [4];
        seq = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] erdy;
            erdy = 4'b0001 << seq[i];
            #1;
            checks++;
            if (in_ready !== erdy) begin
                errors++;
                $display("FAIL rr_sparse_ready[%0d]: in_ready=%b want %b", i, in_ready, erdy);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== seq[i]) begin
                errors++;
                $display("FAIL rr_sparse_ch[%0d]: valid=%b ch=%0d want 1/%0d",
                         i, out_valid, out_ch, seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        step();              // ch0 loaded, FULL
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: in_ready=%b want 0000", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 || out_ch !== 2'd0 || cnt !== 16'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d cnt=%0d, want 1/10/0/1",
                         i, out_valid, out_data, out_ch, cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b want 0010", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1 || cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_release: valid=%b data=%h ch=%0d cnt=%0d, want 1/11/1/2",
                     out_valid, out_data, out_ch, cnt);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;    // held beat ch1 stays FULL
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstfull_ready: in_ready=%b want 0000", in_ready);
        end
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstfull_state: valid=%b cnt=%0d, want 0/0", out_valid, cnt);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstfull_first_ready: in_ready=%b want 0001", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL rstfull_first: valid=%b ch=%0d data=%h cnt=%0d, want 1/0/10/1",
                     out_valid, out_ch, out_data, cnt);
        end
    endtask

    task automatic test_nch3();
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1; out_ready3 = 1'b1;
        in_data3 = {8'hC2, 8'hC1, 8'hC0};
        in_valid3 = 3'b111;
        step();
        rst3 = 1'b0;
        step();
        checks++;
        if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'hC1) begin
            errors++;
            $display("FAIL n3_fixed: valid=%b ch=%0d data=%h, want 1/1/c1",
                     out_valid3, out_ch3, out_data3);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            errors++;
            $display("FAIL n3_sel3_ready: in_ready=%b want 000", in_ready3);
        end
        step();
        checks++;
        if (out_valid3 !== 1'b0 || out_ch3 !== 2'd1 || cnt3 !== 16'd1) begin
            errors++;
            $display("FAIL n3_sel3: valid=%b ch=%0d cnt=%0d, want 0/1/1",
                     out_valid3, out_ch3, cnt3);
        end
        // RR from ptr=1 must visit 2 then wrap to 0.
        mode3 = 1'b1;
        step();
        checks++;
        if (out_ch3 !== 2'd2) begin
            errors++;
            $display("FAIL n3_rr_a: ch=%0d want 2", out_ch3);
        end
        step();
        checks++;
        if (out_ch3 !== 2'd0 || cnt3 !== 16'd3) begin
            errors++;
            $display("FAIL n3_rr_wrap: ch=%0d cnt=%0d want 0/3", out_ch3, cnt3);
        end
        rst3 = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 65535; i++) step();
        checks++;
        if (cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_pre: cnt=%h want ffff", cnt);
        end
        step();
        checks++;
        if (cnt !== 16'h0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: cnt=%h valid=%b want 0000/1", cnt, out_valid);
        end
    endtask

    initial begin
        rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        in_data3 = '0; in_valid3 = '0;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_reset_full();
        test_nch3();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
